capture_window_ctrl: RTL and testbench



---
 rtl/capture_window_ctrl.sv | 157 +++++++++++++++
 tb/tb_capture_window_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_window_ctrl.sv
// Capture window controller: keeps P pre-trigger samples, fills the rest of a 2^ADDR_WIDTH ring after
// the trigger and reports the window start. Optional trigger timestamp via CAPTURE_TIMESTAMP_EN.
module capture_window_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int TS_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger_in,
    input  logic [ADDR_WIDTH-1:0] trigger_position,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]   trigger_timestamp
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0] p_q, p_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH:0]   post_cnt_q, post_cnt_d;

    logic [ADDR_WIDTH-1:0] pre_cnt_inc;
    logic [ADDR_WIDTH:0]   post_cnt_inc;
    logic [ADDR_WIDTH:0]   post_len;
    logic                  trig_accept;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0]   trig_ts_q, trig_ts_d;
`endif

    assign pre_cnt_inc  = pre_cnt_q + 1'b1;
    assign post_cnt_inc = post_cnt_q + 1'b1;
    // Post-trigger samples needed, trigger sample included; needs one extra bit for P=0.
    assign post_len     = DEPTH_V - {1'b0, p_q};

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        p_d          = p_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_accept  = 1'b0;
        if (clk_enable) begin
            if (abort) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (arm) begin
                            p_d       = trigger_position;
                            wr_addr_d = '0;
                            pre_cnt_d = '0;
                            state_d   = (trigger_position == '0) ? WAIT_TRIG : PRE_FILL;
                        end
                    end
                    PRE_FILL: begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == p_q) state_d = WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        if (trigger_in) begin
                            trig_accept  = 1'b1;
                            trig_addr_d  = wr_addr_q;
                            start_addr_d = wr_addr_q - p_q;
                            post_cnt_d   = {{ADDR_WIDTH{1'b0}}, 1'b1};
                            state_d      = (post_len == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? DONE : POST;
                        end
                    end
                    POST: begin
                        wr_addr_d  = wr_addr_q + 1'b1;
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == post_len) state_d = DONE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    always_comb begin
        ts_cnt_d  = ts_cnt_q;
        trig_ts_d = trig_ts_q;
        if (clk_enable) ts_cnt_d = ts_cnt_q + 1'b1;
        if (trig_accept) trig_ts_d = ts_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt_q  <= '0;
            trig_ts_q <= '0;
        end else begin
            ts_cnt_q  <= ts_cnt_d;
            trig_ts_q <= trig_ts_d;
        end
    end

    assign trigger_timestamp = trig_ts_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            p_q          <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            p_q          <= p_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
        end
    end

    assign busy         = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign triggered    = (state_q == POST) || (state_q == DONE);
    assign done         = (state_q == DONE);
    assign wr_en        = clk_enable & busy;
    assign wr_addr      = wr_addr_q;
    assign trigger_addr = trig_addr_q;
    assign start_addr   = start_addr_q;

endmodule

// File: tb/tb_capture_window_ctrl.sv
// Directed bench for capture_window_ctrl with a 16-entry ring (ADDR_WIDTH=4).
module tb_capture_window_ctrl;

    localparam int AW = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_enable;
    logic          arm;
    logic          abort;
    logic          trigger_in;
    logic [AW-1:0] trigger_position;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] trigger_addr;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          triggered;
    logic          done;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [TW-1:0] trigger_timestamp;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int wq[$];
    int bad_we = 0;

    capture_window_ctrl #(.ADDR_WIDTH(AW), .TS_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .arm(arm), .abort(abort),
        .trigger_in(trigger_in), .trigger_position(trigger_position), .wr_en(wr_en),
        .wr_addr(wr_addr), .trigger_addr(trigger_addr), .start_addr(start_addr),
        .busy(busy), .triggered(triggered), .done(done)
`ifdef CAPTURE_TIMESTAMP_EN
        , .trigger_timestamp(trigger_timestamp)
`endif
    );

    always #5 clk = ~clk;

    // Record every write address; flag any strobe outside an enabled cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back(int'(wr_addr));
        if (wr_en === 1'b1 && clk_enable !== 1'b1) bad_we++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clk_enable = 1'b1; arm = 1'b0; abort = 1'b0;
        trigger_in = 1'b0; trigger_position = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Arms with position p, pulses trigger on write number trig_w (1-based) or holds it high,
    // optionally toggling clk_enable, until done or a cycle budget expires.
    task automatic capture(input int p, input int trig_w, input bit hold, input bit toggle,
                           output bit timeout);
        int nw;
        int cyc;
        bit en;
        wq.delete(); bad_we = 0;
        clk_enable = 1'b1; arm = 1'b1; trigger_position = AW'(p); trigger_in = hold;
        tick();
        arm = 1'b0; nw = 0; cyc = 0; en = 1'b1; timeout = 1'b0;
        while (done !== 1'b1) begin
            if (cyc > 400) begin timeout = 1'b1; break; end
            if (toggle) en = ~en;
            clk_enable = en;
            #1;
            if (wr_en === 1'b1) nw++;
            trigger_in = hold || (wr_en === 1'b1 && nw == trig_w);
            @(posedge clk); #1;
            cyc++;
        end
        trigger_in = 1'b0; clk_enable = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (wr_addr !== 4'd0) begin n_bad++; $display("FAIL rst_wr_addr got %0d want 0", wr_addr); end
        n_cmp++; if (trigger_addr !== 4'd0) begin n_bad++; $display("FAIL rst_trig_addr got %0d want 0", trigger_addr); end
        n_cmp++; if (start_addr !== 4'd0) begin n_bad++; $display("FAIL rst_start_addr got %0d want 0", start_addr); end
        n_cmp++; if ({busy, triggered, done} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {busy, triggered, done}); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_basic();
        bit to;
        int bad;
        capture(4, 10, 1'b0, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout got timeout want done"); end
        // Window is 5..15,0..4: 4 pre + 6 waiting (trigger at 9) + 11 post = 21 writes.
        n_cmp++; if (wq.size() != 21) begin n_bad++; $display("FAIL basic_nwrites got %0d want 21", wq.size()); end
        bad = 0;
        foreach (wq[i]) if (wq[i] != i % 16) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL basic_addr_seq got %0d wrong want 0", bad); end
        n_cmp++; if (trigger_addr !== 4'd9) begin n_bad++; $display("FAIL basic_trig_addr got %0d want 9", trigger_addr); end
        n_cmp++; if (start_addr !== 4'd5) begin n_bad++; $display("FAIL basic_start_addr got %0d want 5", start_addr); end
        n_cmp++; if ({busy, triggered, done} !== 3'b011) begin n_bad++; $display("FAIL basic_flags got %b want 011", {busy, triggered, done}); end
        tick(); tick(); tick();
        n_cmp++; if (wq.size() != 21) begin n_bad++; $display("FAIL done_no_write got %0d want 21", wq.size()); end
        n_cmp++; if (start_addr !== 4'd5 || done !== 1'b1) begin n_bad++; $display("FAIL done_hold got start %0d done %b want 5 1", start_addr, done); end
    endtask

    task automatic test_p0();
        bit to;
        int bad;
        capture(0, 1, 1'b0, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL p0_timeout got timeout want done"); end
        n_cmp++; if (wq.size() != 16) begin n_bad++; $display("FAIL p0_nwrites got %0d want 16", wq.size()); end
        bad = 0;
        foreach (wq[i]) if (wq[i] != i % 16) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL p0_addr_seq got %0d wrong want 0", bad); end
        n_cmp++; if (trigger_addr !== 4'd0 || start_addr !== 4'd0) begin n_bad++; $display("FAIL p0_addrs got %0d/%0d want 0/0", trigger_addr, start_addr); end
    endtask

    task automatic test_p15();
        bit to;
        int bad;
        capture(15, 0, 1'b1, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL p15_timeout got timeout want done"); end
        n_cmp++; if (wq.size() != 16) begin n_bad++; $display("FAIL p15_nwrites got %0d want 16", wq.size()); end
        bad = 0;
        foreach (wq[i]) if (wq[i] != i % 16) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL p15_addr_seq got %0d wrong want 0", bad); end
        n_cmp++; if (trigger_addr !== 4'd15) begin n_bad++; $display("FAIL p15_trig_addr got %0d want 15", trigger_addr); end
        n_cmp++; if (start_addr !== 4'd0) begin n_bad++; $display("FAIL p15_start_addr got %0d want 0", start_addr); end
    endtask

    task automatic test_toggle();
        bit to;
        int bad;
        capture(4, 10, 1'b0, 1'b1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL tog_timeout got timeout want done"); end
        n_cmp++; if (wq.size() != 21) begin n_bad++; $display("FAIL tog_nwrites got %0d want 21", wq.size()); end
        bad = 0;
        foreach (wq[i]) if (wq[i] != i % 16) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL tog_addr_seq got %0d wrong want 0", bad); end
        n_cmp++; if (trigger_addr !== 4'd9 || start_addr !== 4'd5) begin n_bad++; $display("FAIL tog_addrs got %0d/%0d want 9/5", trigger_addr, start_addr); end
        n_cmp++; if (bad_we != 0) begin n_bad++; $display("FAIL tog_wr_en_gated got %0d stray want 0", bad_we); end
    endtask

    task automatic test_abort();
        clk_enable = 1'b1; arm = 1'b1; trigger_position = 4'd4;
        tick();
        arm = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            trigger_in = (i == 10);
            tick();
        end
        trigger_in = 1'b0;
        n_cmp++; if ({busy, triggered, done} !== 3'b110) begin n_bad++; $display("FAIL abort_in_post got %b want 110", {busy, triggered, done}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if ({busy, triggered, done} !== 3'b000) begin n_bad++; $display("FAIL abort_flags got %b want 000", {busy, triggered, done}); end
        n_cmp++; if (wr_addr !== 4'd12 || trigger_addr !== 4'd9 || start_addr !== 4'd5) begin n_bad++; $display("FAIL abort_keep got %0d/%0d/%0d want 12/9/5", wr_addr, trigger_addr, start_addr); end
        tick();
        n_cmp++; if (busy !== 1'b0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL abort_idle got busy %b wr_en %b want 0 0", busy, wr_en); end
        arm = 1'b1; trigger_position = 4'd0;
        tick();
        arm = 1'b0;
        n_cmp++; if (busy !== 1'b1 || wr_addr !== 4'd0) begin n_bad++; $display("FAIL rearm got busy %b addr %0d want 1 0", busy, wr_addr); end
        arm = 1'b1; abort = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_arm_busy got %b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_arm_idle got busy %b done %b want 0 0", busy, done); end
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        clk_enable = 1'b1; arm = 1'b1; trigger_position = 4'd4;
        tick();
        arm = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if ({busy, triggered, done} !== 3'b000 || wr_addr !== 4'd0 || trigger_addr !== 4'd0 || start_addr !== 4'd0)
            begin n_bad++; $display("FAIL reset_mid got flags %b addr %0d trig %0d start %0d want 000 0 0 0", {busy, triggered, done}, wr_addr, trigger_addr, start_addr); end
    endtask

`ifdef CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        for (int i = 0; i < 100; i++) tick();
        arm = 1'b1; trigger_position = 4'd0;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            trigger_in = (k == 7);
            tick();
        end
        trigger_in = 1'b0;
        n_cmp++; if (trigger_timestamp !== 32'd107) begin n_bad++; $display("FAIL timestamp got %0d want 107", trigger_timestamp); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_p0();
        test_p15();
        test_toggle();
        test_abort();
        test_reset_mid();
`ifdef CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
